gc_refresh_ctrl: RTL and testbench

GC_REFRESH_CTRL -- requirements
Module: gc_refresh_ctrl

---
 rtl/gc_refresh_ctrl.sv | 159 +++++++++++++++
 tb/tb_gc_refresh_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gc_refresh_ctrl.sv
// Gain-cell DRAM controller: serialises user reads/writes onto the macro and
// periodically reads and writes back one row. Optional macro REFRESH_SKIP_EN skips rows already written since their last visit.
module gc_refresh_ctrl #(
  parameter int REFRESH_PERIOD = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [6:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        re,
  output logic        we,
  output logic [6:0]  raddr,
  output logic [6:0]  waddr,
  output logic [63:0] in,
  input  logic [63:0] rd,
  output logic        refresh_active
);

  localparam int CW = $clog2(REFRESH_PERIOD);
  localparam logic [CW-1:0] PMAX = CW'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, RSP, WR, RF_RD1, RF_RD2, RF_WB
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_period;
  logic [6:0]    r_ptr;
  logic          r_pending;
  logic [63:0]   r_buf;
  logic          r_re;
  logic          r_we;
  logic [6:0]    r_raddr;
  logic [6:0]    r_waddr;
  logic [63:0]   r_in;
  logic          r_rsp_valid;
  logic [63:0]   r_rsp_rdata;
  logic          r_active;

  logic w_tick;
  logic w_skip;

`ifdef REFRESH_SKIP_EN
  logic [127:0] r_dirty;
  assign w_skip = r_dirty[r_ptr];
`else
  assign w_skip = 1'b0;
`endif

  assign w_tick         = (r_period == PMAX);
  assign req_ready      = (r_state == IDLE) && !r_pending && !rst;
  assign re             = r_re;
  assign we             = r_we;
  assign raddr          = r_raddr;
  assign waddr          = r_waddr;
  // Writeback data comes straight from the buffer captured at the RF_RD2 edge.
  assign in             = (r_state == RF_WB) ? r_buf : r_in;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign refresh_active = r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_period    <= '0;
      r_ptr       <= '0;
      r_pending   <= 1'b0;
      r_buf       <= '0;
      r_re        <= 1'b0;
      r_we        <= 1'b0;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_in        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_active    <= 1'b0;
`ifdef REFRESH_SKIP_EN
      r_dirty     <= '0;
`endif
    end else begin
      r_period    <= w_tick ? '0 : r_period + CW'(1);
      r_rsp_valid <= 1'b0;
      // A refresh never outlasts a period, so pending is always clear at a tick.
      if (w_tick && !r_pending) r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_pending) begin
            if (w_skip) begin
              r_ptr     <= r_ptr + 7'd1;
              r_pending <= 1'b0;
`ifdef REFRESH_SKIP_EN
              r_dirty[r_ptr] <= 1'b0;
`endif
            end else begin
              r_state  <= RF_RD1;
              r_re     <= 1'b1;
              r_raddr  <= r_ptr;
              r_active <= 1'b1;
            end
          end else if (req_valid) begin
            if (req_we) begin
              r_state <= WR;
              r_we    <= 1'b1;
              r_waddr <= req_addr;
              r_in    <= req_wdata;
`ifdef REFRESH_SKIP_EN
              r_dirty[req_addr] <= 1'b1;
`endif
            end else begin
              r_state <= RD1;
              r_re    <= 1'b1;
              r_raddr <= req_addr;
            end
          end
        end
        RD1: r_state <= RD2;
        RD2: begin
          r_state     <= RSP;
          r_re        <= 1'b0;
          r_raddr     <= '0;
          r_rsp_rdata <= rd;
          r_rsp_valid <= 1'b1;
        end
        RSP: r_state <= IDLE;
        WR: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_waddr <= '0;
          r_in    <= '0;
        end
        RF_RD1: r_state <= RF_RD2;
        RF_RD2: begin
          r_state <= RF_WB;
          r_re    <= 1'b0;
          r_raddr <= '0;
          r_buf   <= rd;
          r_we    <= 1'b1;
          r_waddr <= r_ptr;
        end
        RF_WB: begin
          r_state   <= IDLE;
          r_we      <= 1'b0;
          r_waddr   <= '0;
          r_ptr     <= r_ptr + 7'd1;
          r_pending <= 1'b0;
          r_active  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_refresh_ctrl.sv
// Self-checking bench for gc_refresh_ctrl: a behavioural gain-cell macro with
// a retention limit, a read-response scoreboard and directed refresh corner cases.
module tb_gc_refresh_ctrl;

  localparam int P = 32;
`ifdef REFRESH_SKIP_EN
  // A skipped row relies on its user write, so it may wait one extra sweep.
  localparam int RETENTION = 9000;
`else
  localparam int RETENTION = 5000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [6:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        re;
  logic        we;
  logic [6:0]  raddr;
  logic [6:0]  waddr;
  logic [63:0] in;
  logic [63:0] rd = '0;
  logic        refresh_active;

  gc_refresh_ctrl #(.REFRESH_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .re(re), .we(we),
    .raddr(raddr), .waddr(waddr), .in(in), .rd(rd),
    .refresh_active(refresh_active)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;
  int reWeViolations = 0;

  typedef struct {
    logic [63:0] data;
    int          hcyc;
  } expect_t;
  expect_t scoreQ[$];

  typedef struct {
    logic        isWrite;
    logic [6:0]  addr;
    logic [63:0] wdata;
    logic [63:0] expData;
  } vec_t;
  vec_t vectors[11];

  logic [63:0] mem[128];
  int          stamp[128];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Macro model: one-cycle registered read; a row decays to X once its age exceeds retention.
  always @(posedge clk) begin
    if (we) begin
      mem[waddr]   <= in;
      stamp[waddr] <= cycleCount;
    end
    if (re) rd <= ((cycleCount - stamp[raddr]) > RETENTION) ? 64'bx : mem[raddr];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest read, exactly 3 cycles on.
  always @(negedge clk) begin
    if (re && we) reWeViolations++;
    if (rsp_valid) begin
      checkOutput("rsp_expected", 64'(scoreQ.size() != 0), 64'd1);
      if (scoreQ.size() != 0) begin
        expect_t e;
        e = scoreQ.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.data);
        checkOutput("rsp_latency", 64'(cycleCount - e.hcyc), 64'd3);
      end
    end
  end

  // Called 1ns after a rising edge; returns 1ns after the handshake edge.
  task automatic applyStimulus(input logic isWrite, input logic [6:0] addr,
                               input logic [63:0] wdata, input logic [63:0] expData);
    int waitCnt;
    waitCnt   = 0;
    req_valid = 1'b1;
    req_we    = isWrite;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    while (!req_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) checkOutput("handshake", 64'(req_ready), 64'd1);
    else if (!isWrite) scoreQ.push_back('{expData, cycleCount});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int waitCnt;
    int accesses;

    for (int i = 0; i < 128; i++) begin
      mem[i]   = 64'h1000 + 64'(i);
      stamp[i] = 0;
    end

    vectors[0]  = '{1'b1, 7'd5,   64'hDEAD_BEEF_0123_4567, 64'h0};
    vectors[1]  = '{1'b0, 7'd5,   64'h0, 64'hDEAD_BEEF_0123_4567};
    vectors[2]  = '{1'b1, 7'd0,   64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vectors[3]  = '{1'b1, 7'd127, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0};
    vectors[4]  = '{1'b0, 7'd0,   64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    vectors[5]  = '{1'b0, 7'd127, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A};
    vectors[6]  = '{1'b1, 7'd5,   64'h0123_4567_89AB_CDEF, 64'h0};
    vectors[7]  = '{1'b0, 7'd5,   64'h0, 64'h0123_4567_89AB_CDEF};
    vectors[8]  = '{1'b1, 7'd64,  64'h5555_AAAA_0000_FFFF, 64'h0};
    vectors[9]  = '{1'b0, 7'd64,  64'h0, 64'h5555_AAAA_0000_FFFF};
    vectors[10] = '{1'b0, 7'd127, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_ctrl", 64'({re, we, rsp_valid, refresh_active, raddr, waddr}), 64'd0);
    checkOutput("rst_in", in, 64'd0);
    checkOutput("rst_rdata", rsp_rdata, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // The first tick lands on edge P after release; a read held from then must wait out row 0's refresh.
    repeat (P - 1) @(posedge clk);
    @(negedge clk);
    checkOutput("release_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd0;
    @(negedge clk);
    checkOutput("tick_ready_low", 64'(req_ready), 64'd0);
    checkOutput("tick_active_low", 64'(refresh_active), 64'd0);
    @(negedge clk);
    checkOutput("rf_rd1_active", 64'(refresh_active), 64'd1);
    checkOutput("rf_rd1_re", 64'({re, we}), 64'b10);
    checkOutput("rf_rd1_raddr", 64'(raddr), 64'd0);
    checkOutput("rf_rd1_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rf_wb_we", 64'({re, we}), 64'b01);
    checkOutput("rf_wb_waddr", 64'(waddr), 64'd0);
    checkOutput("rf_wb_in", in, 64'h1000);
    @(negedge clk);
    checkOutput("post_rf_ready", 64'(req_ready), 64'd1);
    checkOutput("post_rf_active", 64'(refresh_active), 64'd0);
    if (req_ready) scoreQ.push_back('{64'h1000, cycleCount});
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    for (int i = 0; i < 11; i++)
      applyStimulus(vectors[i].isWrite, vectors[i].addr, vectors[i].wdata, vectors[i].expData);
    repeat (6) @(posedge clk);
    #1;

    // Retention sweep: every row must survive a long idle stretch on refresh alone.
    for (int a = 0; a < 128; a++) applyStimulus(1'b1, 7'(a), 64'(a), 64'h0);
    repeat (5200) @(posedge clk);
    #1;
    for (int a = 0; a < 128; a++) applyStimulus(1'b0, 7'(a), 64'h0, 64'(a));
    repeat (6) @(posedge clk);
    #1;

    // Abort a refresh with reset while it sits in RF_RD2.
    waitCnt = 0;
    while (refresh_active && waitCnt < 100) begin @(negedge clk); waitCnt++; end
    while (!refresh_active && waitCnt < 200) begin @(negedge clk); waitCnt++; end
    checkOutput("rf_found", 64'(refresh_active), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_we", 64'(we), 64'd0);
    checkOutput("abort_re", 64'(re), 64'd0);
    checkOutput("abort_active", 64'(refresh_active), 64'd0);
    checkOutput("abort_ptr", 64'(dut.r_ptr), 64'd0);
    checkOutput("abort_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef REFRESH_SKIP_EN
    applyStimulus(1'b1, 7'd0, 64'h0BAD_F00D, 64'h0);
    @(posedge clk);
    #1;
    accesses = 0;
    waitCnt  = 0;
    while (dut.r_ptr != 7'd1 && waitCnt < 3 * P) begin
      @(negedge clk);
      if (re || we) accesses++;
      waitCnt++;
    end
    checkOutput("skip_no_access", 64'(accesses), 64'd0);
    checkOutput("skip_ptr", 64'(dut.r_ptr), 64'd1);
    checkOutput("skip_dirty0", 64'(dut.r_dirty[0]), 64'd0);
`else
    accesses = 0;
`endif

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(scoreQ.size()), 64'd0);
    checkOutput("re_we_exclusive", 64'(reWeViolations + accesses), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
